// File: rtl/snn_inference_ctrl_pkg.sv
// Shared types and helpers for the spiking-network inference controller.
// Holds the FSM state encoding, default geometry and the saturating counter step.
package snn_ctrl_pkg;

    localparam int DEF_IN_W    = 8;
    localparam int DEF_OUT_W   = 8;
    localparam int DEF_NET_LAT = 2;
    localparam int DEF_STEP_W  = 8;
    localparam int DEF_CNT_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STEP,
        ST_WAIT,
        ST_SCAN,
        ST_DONE
    } state_t;

    // Callers zero-extend into 32 bits and truncate the result back to their width.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/snn_inference_ctrl_if.sv
// Host-side sample/result handshakes plus the layer-chain control bus.
// master = the controller's view; slave = host and network side.
interface snn_inference_ctrl_if
    import snn_ctrl_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int STEP_W = DEF_STEP_W,
    parameter int CNT_W  = DEF_CNT_W
);
    logic                     in_valid;
    logic                     in_ready;
    logic [IN_W-1:0]          in_spike;
    logic [STEP_W-1:0]        in_steps;
    logic                     in_early;
    logic                     net_clear;
    logic                     net_step;
    logic [IN_W-1:0]          net_spike_in;
    logic [OUT_W-1:0]         net_spike_out;
    logic                     res_valid;
    logic                     res_ready;
    logic [$clog2(OUT_W)-1:0] res_class;
    logic [CNT_W-1:0]         res_count;
    logic                     res_tie;
    logic [STEP_W-1:0]        res_steps;

    modport master (
        input  in_valid, in_spike, in_steps, in_early, net_spike_out, res_ready,
        output in_ready, net_clear, net_step, net_spike_in,
               res_valid, res_class, res_count, res_tie, res_steps
    );

    modport slave (
        output in_valid, in_spike, in_steps, in_early, net_spike_out, res_ready,
        input  in_ready, net_clear, net_step, net_spike_in,
               res_valid, res_class, res_count, res_tie, res_steps
    );

endinterface

// File: rtl/snn_inference_ctrl_argmax_scan.sv
// Sequential argmax over N counters, one index per cycle; lowest index wins ties.
// Latency: N cycles after the start pulse, done is high during the last one.
// Backpressure: none; start is only issued by the controller while idle.
module snn_argmax_scan #(
    parameter int N     = 8,
    parameter int CNT_W = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] cnt,
    output logic [IDX_W-1:0] idx,
    output logic             done,
    output logic [CNT_W-1:0] max_cnt,
    output logic [IDX_W-1:0] max_idx,
    output logic             tie
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    logic busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy    <= 1'b0;
            idx     <= '0;
            max_cnt <= '0;
            max_idx <= '0;
            tie     <= 1'b0;
        end else if (start) begin
            busy <= 1'b1;
            idx  <= '0;
        end else if (busy) begin
            if (idx == '0) begin
                max_cnt <= cnt;
                max_idx <= '0;
                tie     <= 1'b0;
            end else if (cnt > max_cnt) begin
                max_cnt <= cnt;
                max_idx <= idx;
                tie     <= 1'b0;
            end else if (cnt == max_cnt) begin
                tie <= 1'b1;
            end
            if (idx == LAST) busy <= 1'b0;
            else             idx  <= idx + 1'b1;
        end
    end

    assign done = busy && (idx == LAST);

endmodule

// File: rtl/snn_inference_ctrl.sv
// Sequences one inference: clear membranes, T net steps, count output spikes, argmax.
// Latency: result valid after 1 + S*(1+NET_LAT) + OUT_W edges from the accept edge.
// Backpressure: in_ready only in IDLE; the result is held in DONE until res_ready.
module snn_inference_ctrl
    import snn_ctrl_pkg::*;
#(
    parameter int IN_W    = DEF_IN_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int NET_LAT = DEF_NET_LAT,
    parameter int STEP_W  = DEF_STEP_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    snn_inference_ctrl_if.master  bus
);
    localparam int          CLS_W   = $clog2(OUT_W);
    localparam int          WAIT_W  = (NET_LAT > 1) ? $clog2(NET_LAT) : 1;
    localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q;
    logic [STEP_W-1:0]   steps_q;
    logic [STEP_W-1:0]   steps_done_q;
    logic [STEP_W-1:0]   steps_next;
    logic                early_q;
    logic [IN_W-1:0]     spike_q;
    logic [CNT_W-1:0]    cnt_q [OUT_W];

    logic                in_ready, net_clear, net_step, res_valid, scan_start;
    logic                scan_done;
    logic [CLS_W-1:0]    scan_idx;
    logic [CNT_W-1:0]    scan_cnt;
    logic [CLS_W-1:0]    res_class_q;
    logic [CNT_W-1:0]    res_count_q;
    logic                res_tie_q;

    assign steps_next = steps_done_q + STEP_W'(1);

    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        net_clear  = 1'b0;
        net_step   = 1'b0;
        res_valid  = 1'b0;
        scan_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                net_clear = 1'b1;
                state_d   = ST_STEP;
            end
            ST_STEP: begin
                net_step = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                // Only the final wait cycle sees valid network output.
                if (wait_q == '0) begin
                    if ((steps_next == steps_q) || (early_q && (|bus.net_spike_out))) begin
                        state_d    = ST_SCAN;
                        scan_start = 1'b1;
                    end else begin
                        state_d = ST_STEP;
                    end
                end
            end
            ST_SCAN: begin
                if (scan_done) state_d = ST_DONE;
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (bus.res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            wait_q       <= '0;
            steps_q      <= '0;
            steps_done_q <= '0;
            early_q      <= 1'b0;
            spike_q      <= '0;
            for (int i = 0; i < OUT_W; i++) cnt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        spike_q <= bus.in_spike;
                        steps_q <= (bus.in_steps == '0) ? STEP_W'(1) : bus.in_steps;
                        early_q <= bus.in_early;
                    end
                end
                ST_CLEAR: begin
                    steps_done_q <= '0;
                    for (int i = 0; i < OUT_W; i++) cnt_q[i] <= '0;
                end
                ST_STEP: wait_q <= WAIT_W'(NET_LAT - 1);
                ST_WAIT: begin
                    if (wait_q != '0) begin
                        wait_q <= wait_q - 1'b1;
                    end else begin
                        steps_done_q <= steps_next;
                        for (int i = 0; i < OUT_W; i++) begin
                            if (bus.net_spike_out[i])
                                cnt_q[i] <= CNT_W'(sat_inc(32'(cnt_q[i]), CNT_MAX));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign scan_cnt = cnt_q[scan_idx];

    snn_argmax_scan #(
        .N     (OUT_W),
        .CNT_W (CNT_W),
        .IDX_W (CLS_W)
    ) u_scan (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (scan_start),
        .cnt     (scan_cnt),
        .idx     (scan_idx),
        .done    (scan_done),
        .max_cnt (res_count_q),
        .max_idx (res_class_q),
        .tie     (res_tie_q)
    );

    assign bus.in_ready     = in_ready;
    assign bus.net_clear    = net_clear;
    assign bus.net_step     = net_step;
    assign bus.net_spike_in = spike_q;
    assign bus.res_valid    = res_valid;
    assign bus.res_class    = res_class_q;
    assign bus.res_count    = res_count_q;
    assign bus.res_tie      = res_tie_q;
    assign bus.res_steps    = steps_done_q;

endmodule
